// File: rtl/vga_scan_out.sv
// Raster timing generator and final pixel output stage for a 640x480 VGA display.
// It produces addresses for the renderer and applies the mask, blanking and sync with one slot of latency.
module vga_scan_out #(
    parameter int DIV      = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_in,
    input  logic [11:0] mask_in,
    output logic [8:0]  row_addr,
    output logic [9:0]  col_addr,
    output logic        rdn,
    output logic        clk_frame,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hs,
    output logic        vs
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = $clog2(DIV);
    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = (SYNC_POL == 0);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_last;
    logic             v_last;
    logic             in_vis;
    logic             in_hsync;
    logic             in_vsync;
    logic             in_vblank;
    logic             hsync_p0;
    logic             vsync_p0;

    function automatic logic [11:0] blank_mask(input logic [11:0] pix,
                                               input logic [11:0] msk,
                                               input logic        blank);
        return blank ? 12'h000 : (pix & msk);
    endfunction

    // h_cnt/v_cnt hold the position of the slot that starts at the next pix_en.
    always_comb begin
        pix_en    = (div_cnt == DIV_W'(DIV - 1));
        h_last    = (h_cnt == 10'(H_TOTAL - 1));
        v_last    = (v_cnt == 10'(V_TOTAL - 1));
        in_vis    = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
        in_hsync  = (h_cnt >= 10'(HS_START)) && (h_cnt <= 10'(HS_END));
        in_vsync  = (v_cnt >= 10'(VS_START)) && (v_cnt <= 10'(VS_END));
        in_vblank = (v_cnt >= 10'(V_VIS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last) begin
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    // Stage p0: slot k address, enable, sync flags and frame pacing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_addr  <= '0;
            row_addr  <= '0;
            rdn       <= 1'b1;
            hsync_p0  <= 1'b0;
            vsync_p0  <= 1'b0;
            clk_frame <= 1'b0;
        end else if (pix_en) begin
            col_addr  <= h_cnt;
            row_addr  <= v_cnt[8:0];
            rdn       <= ~in_vis;
            hsync_p0  <= in_hsync;
            vsync_p0  <= in_vsync;
            clk_frame <= in_vblank;
        end
    end

    // Stage p1: pixel for slot k and its sync, driven during slot k+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {vga_r, vga_g, vga_b} <= 12'h000;
            hs                    <= SYNC_IDLE;
            vs                    <= SYNC_IDLE;
        end else if (pix_en) begin
            {vga_r, vga_g, vga_b} <= blank_mask(pixel_in, mask_in, rdn);
            hs                    <= hsync_p0 ? SYNC_ACT : SYNC_IDLE;
            vs                    <= vsync_p0 ? SYNC_ACT : SYNC_IDLE;
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: full-width lines with a shortened vertical raster so two frames fit in the run.
// Expected positions come from the absolute slot index; pixel results flow through a queue with one slot of lag.
module tb_vga_scan_out;

    localparam int DIV = 4;
    localparam int HT  = 800;
    localparam int VT  = 10;
    localparam int NV  = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_in = 12'h000;
    logic [11:0] mask_in  = 12'h000;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic        clk_frame;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hs;
    logic        vs;

    always #5 clk = ~clk;

    vga_scan_out #(
        .DIV(DIV), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .mask_in(mask_in),
        .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn), .clk_frame(clk_frame),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hs(hs), .vs(vs)
    );

    typedef struct {
        logic [11:0] pix;
        logic [11:0] msk;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } vec_t;

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   slot     = -1;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s slot=%0d got=%0h want=%0h", name, slot, act, exp);
        end
    endtask

    task automatic sb_reset();
        exp_t e;
        e.r = 4'h0; e.g = 4'h0; e.b = 4'h0; e.hs = 1'b1; e.vs = 1'b1;
        sb.delete();
        sb.push_back(e);
        slot = -1;
    endtask

    task automatic step_slot();
        exp_t e;
        exp_t n;
        int   h;
        int   v;
        bit   vis;
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        slot++;
        h   = slot % HT;
        v   = (slot / HT) % VT;
        vis = (h < 640) && (v < 6);
        chk("col_addr", int'(col_addr), h);
        chk("row_addr", int'(row_addr), v);
        chk("rdn", int'(rdn), int'(!vis));
        chk("clk_frame", int'(clk_frame), int'(v >= 6));
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("vga_r", int'(vga_r), int'(e.r));
            chk("vga_g", int'(vga_g), int'(e.g));
            chk("vga_b", int'(vga_b), int'(e.b));
            chk("hs", int'(hs), int'(e.hs));
            chk("vs", int'(vs), int'(e.vs));
        end
        if (v == 5 && h >= 10 && h < 10 + NV) begin
            pixel_in = vecs[h-10].pix;
            mask_in  = vecs[h-10].msk;
            n.r = vecs[h-10].r; n.g = vecs[h-10].g; n.b = vecs[h-10].b;
        end else begin
            pixel_in = 12'hFFF;
            mask_in  = 12'hFFF;
            n.r = vis ? 4'hF : 4'h0;
            n.g = vis ? 4'hF : 4'h0;
            n.b = vis ? 4'hF : 4'h0;
        end
        n.hs = !(h >= 656 && h <= 751);
        n.vs = !(v >= 7 && v <= 8);
        sb.push_back(n);
    endtask

    initial begin
        int rdn_low, hs_cnt, hs_first, vs_cnt, vs_first;
        int rises, rise1_slot, rise2_slot, rise1_cyc, rise2_cyc, fall_slot;
        bit cf_prev;

        vecs[0] = '{12'hABC, 12'hF0F, 4'hA, 4'h0, 4'hC};
        vecs[1] = '{12'hABC, 12'h000, 4'h0, 4'h0, 4'h0};
        vecs[2] = '{12'hFFF, 12'hFFF, 4'hF, 4'hF, 4'hF};
        vecs[3] = '{12'h123, 12'hFFF, 4'h1, 4'h2, 4'h3};
        vecs[4] = '{12'hFFF, 12'h0F0, 4'h0, 4'hF, 4'h0};
        vecs[5] = '{12'h5A5, 12'hA5A, 4'h0, 4'h0, 4'h0};
        vecs[6] = '{12'h9C3, 12'hF55, 4'h9, 4'h4, 4'h1};

        // Power-on reset, then scan to mid-line (h=300, v=3) and reset asynchronously
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb_reset();
        while (slot < 3 * HT + 300) step_slot();
        #2 rst = 1'b1;
        #1;
        chk("rst_col", int'(col_addr), 0);
        chk("rst_row", int'(row_addr), 0);
        chk("rst_rdn", int'(rdn), 1);
        chk("rst_frame", int'(clk_frame), 0);
        chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("rst_hs", int'(hs), 1);
        chk("rst_vs", int'(vs), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cadence: col_addr steps once every DIV clocks, first slot is (0,0) visible
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("cad_col", int'(col_addr), (n < 4) ? 0 : (n / 4 - 1));
            chk("cad_rdn", int'(rdn), int'(n < 4));
            chk("cad_row", int'(row_addr), 0);
        end

        // Two frames from a fresh reset with line/frame statistics
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_reset();
        rdn_low = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1;
        rises = 0; rise1_slot = -1; rise2_slot = -1; rise1_cyc = 0; rise2_cyc = 0;
        fall_slot = -1; cf_prev = 1'b0;
        while (slot < 13000) begin
            step_slot();
            if (slot < 800 && !rdn) rdn_low++;
            if (slot >= 1 && slot <= 800 && !hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = slot;
            end
            if (slot >= 1 && slot <= 8000 && !vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = slot;
            end
            if (clk_frame && !cf_prev) begin
                rises++;
                if (rises == 1) begin rise1_slot = slot; rise1_cyc = cyc; end
                if (rises == 2) begin rise2_slot = slot; rise2_cyc = cyc; end
            end
            if (!clk_frame && cf_prev && fall_slot < 0) fall_slot = slot;
            cf_prev = clk_frame;
        end
        chk("line_rdn_low", rdn_low, 640);
        chk("line_hs_len", hs_cnt, 96);
        chk("line_hs_first", hs_first, 657);
        chk("frame_vs_len", vs_cnt, 1600);
        chk("frame_vs_first", vs_first, 5601);
        chk("frame_rises", rises, 2);
        chk("frame_rise1", rise1_slot, 4800);
        chk("frame_rise2", rise2_slot, 12800);
        chk("frame_fall", fall_slot, 8000);
        chk("frame_period", rise2_cyc - rise1_cyc, 32000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Raster timing generator and final pixel output stage for the 640x480 display.
- Generates `row_addr`/`col_addr` for the renderer and the zoom/mask controller, plus the per-frame `clk_frame` edge that paces game logic.
- Takes the rendered 12-bit pixel and the 12-bit mask back in, ANDs them, and drives the VGA RGB and sync pins with the pipeline delay matched.

Parameters:
- DIV, 4: system clocks per pixel slot; pixel enable fires once every DIV clocks; DIV >= 2.
- H_VIS, 640: visible columns.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VIS, 480: visible rows.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync active level (0 = active-low).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pixel_in  in  12  rendered colour {R[11:8], G[7:4], B[3:0]} for the address presented in the current slot
- mask_in  in  12  brightness mask for the same address
- row_addr  out  9  current row (0..479 when visible)
- col_addr  out  10  current column (0..639 when visible)
- rdn  out  1  active-low display-enable for the current slot
- clk_frame  out  1  frame pacing level; rises once per frame
- vga_r  out  4  red output
- vga_g  out  4  green output
- vga_b  out  4  blue output
- hs  out  1  horizontal sync
- vs  out  1  vertical sync

Behaviour:
- Clock/reset: one clock domain. `rst` is asynchronous and active-high.
- Reset values: divider=0, h_cnt=0, v_cnt=0, row_addr=0, col_addr=0, rdn=1, clk_frame=0, vga_r/g/b=0, hs=vs=~SYNC_POL. Reset mid-frame restarts at (0,0) with no partial-line artefacts.
- Divider: counts 0..DIV-1 and wraps. pix_en is asserted when divider==DIV-1. All counters and the output pipeline advance only on pix_en.
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800.
- v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525. v_cnt increments when h_cnt wraps from 799 to 0; v_cnt wraps from 524 to 0.
- Segment order, horizontal: visible [0,639], front porch [640,655], sync [656,751], back porch [752,799].
- Segment order, vertical: visible [0,479], front porch [480,489], sync [490,491], back porch [492,524].
- row_addr/col_addr/rdn are registered from the counters and are valid for the whole of slot k.
  - rdn=0 iff h_cnt<640 and v_cnt<480.
  - Outside the visible region: col_addr=h_cnt[9:0], row_addr=v_cnt[8:0] (aliasing above 511 permitted). Consumers ignore them when rdn=1.
- Upstream contract: pixel_in and mask_in must be stable for slot k's address by the final clk of slot k.
- Output pipeline (1 pixel-slot latency): at the pix_en ending slot k, the stage captures {pixel_in & mask_in, rdn_k, hsync_k, vsync_k}. vga_r/g/b/hs/vs for slot k are driven throughout slot k+1.
  - RGB is forced to 0 when the captured rdn_k=1.
  - hs/vs are delayed by the same single slot, so colour and sync stay aligned.
- hsync_k: active (==SYNC_POL) iff 656<=h_cnt<=751. vsync_k: active iff 490<=v_cnt<=491.
- clk_frame is registered: 1 iff v_cnt>=480.
  - Rising edge exactly once per frame, on the slot where v_cnt becomes 480 at h_cnt=0.
  - Stays high through vertical blanking; falls when v_cnt wraps to 0.
  - Glitch-free; safe to use as a clock.
- Frame period: 800*525*DIV clocks = 1,680,000 at DIV=4.
- No handshake back-pressure: the scan never stalls.

Test Plan:
- Reset: assert rst asynchronously mid-line at h=300, v=200 -> all outputs take reset values immediately; after release, the first pix_en presents col_addr=0, row_addr=0, rdn=0.
- Cadence: DIV=4, free-run 20 clocks -> col_addr advances exactly every 4 clocks (0,1,2,3,4); pix_en never on consecutive clocks.
- Line timing: observe one line -> hs active for 96 slots starting when the delayed slot corresponds to h=656; rdn low for exactly 640 slots; line length 800 slots.
- Frame timing: observe one frame -> vs active for exactly 2 lines (v=490,491 plus one slot of latency); clk_frame rises once at (h=0, v=480), falls at v wrap; period 1,680,000 clocks.
- Masking/latency: pixel_in=12'hABC, mask_in=12'hF0F at slot (col 10, row 5) -> during the next slot vga_r=4'hA, vga_g=4'h0, vga_b=4'hC; mask_in=12'h000 -> RGB=0.
- Blanking: pixel_in=12'hFFF, mask_in=12'hFFF held constant -> RGB=0 during every slot following h>=640 or v>=480; RGB=F,F,F during visible slots.
